thor2023_inta_master: RTL
=========================

THOR2023_INTA_MASTER -- requirements
Module: Thor2023_inta_master

Interface
REQ-001 SHALL have parameter CORE_ID, default 6'd0, meaning the core number this block answers for; 6'h3F on core_i is broadcast.
REQ-002 SHALL have parameter NMI_CAUSE, default 8'h02, meaning the cause code reported for NMI.
REQ-003 SHALL have parameter SPURIOUS_CAUSE, default 8'd24, meaning the cause code for a spurious or timed-out acknowledge.
REQ-004 SHALL have parameter TIMEOUT, default 16, meaning the acknowledge-cycle watchdog length in clocks.
REQ-005 SHALL have port clk_i, input, 1, the single clock.
REQ-006 SHALL have port rst_ni, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have ports irq_i (input, 4), cause_i (input, 8) and core_i (input, 6): the controller's registered level, cause and target core.
REQ-008 SHALL have port nmi_i, input, 1, the controller's NMI output.
REQ-009 SHALL have ports ipl_i (input, 4), the core's current mask level, and ie_i (input, 1), the core's global interrupt enable.
REQ-010 SHALL have bus-master outputs cyc_o, stb_o, we_o (1 each), cti_o (3), sel_o (4) and adr_o (32).
REQ-011 SHALL have bus inputs ack_i (1), dat_i (32) and vp_i (1); vp_i is the vector-pull indication.
REQ-012 SHALL have core-side outputs irq_valid_o (1), irq_nmi_o (1), irq_spurious_o (1), irq_level_o (4) and irq_cause_o (8), plus input irq_take_i (1).

Function
REQ-013 SHALL capture irq_i, cause_i and core_i each clock and treat a request as qualified only when all hold for 2 consecutive clocks with identical values: irq_i!=0, irq_i>ipl_i, ie_i=1, and core_i==CORE_ID or core_i==6'h3F.
REQ-014 SHALL register nmi_i and set an NMI-pending flag on each 0->1 edge; NMI SHALL ignore ie_i, ipl_i and core_i.
REQ-015 SHALL implement the FSM IDLE -> INTA -> PEND -> IDLE, plus the path IDLE -> PEND for NMI.
REQ-016 IDLE: when NMI is pending, SHALL go to PEND with cause NMI_CAUSE, level 4'hF and irq_nmi_o=1, and SHALL clear the pending flag; NMI SHALL win over a simultaneous maskable request.
REQ-017 IDLE: when a maskable request is qualified, SHALL latch level and cause and go to INTA on the next clock.
REQ-018 INTA: SHALL drive cyc_o=stb_o=1, we_o=0, cti_o=3'b110, sel_o=4'hF and adr_o={28'hFFFFFFF, level[2:0], 1'b0}, all held stable until the cycle ends.
REQ-019 INTA ack: on ack_i=1, SHALL take cause=dat_i[7:0], drop cyc_o/stb_o the same edge and go to PEND.
REQ-020 INTA spurious: when dat_i[7:0]==SPURIOUS_CAUSE, SHALL set irq_spurious_o=1.
REQ-021 INTA vector pull: on vp_i=1 without ack_i, SHALL end the cycle and keep the latched cause_i as the cause.
REQ-022 INTA ack and vp_i together: ack_i SHALL take precedence over vp_i.
REQ-023 INTA timeout: a counter SHALL clear on entry to INTA and increment each clock; when it reaches TIMEOUT-1 with no ack_i or vp_i, SHALL end the cycle, set cause=SPURIOUS_CAUSE and irq_spurious_o=1, and go to PEND.
REQ-024 INTA withdrawal: if the request drops during INTA, the cycle SHALL still complete.
REQ-025 PEND: irq_valid_o=1 with level, cause, nmi and spurious held stable; on irq_take_i=1, SHALL clear irq_valid_o, irq_nmi_o and irq_spurious_o and return to IDLE the next clock.
REQ-026 PEND: new requests and NMI edges SHALL be ignored except that NMI edges still set the pending flag.
REQ-027 After returning from PEND, SHALL require a fresh 2-clock qualification before the next INTA.
REQ-028 SHALL keep irq_take_i high-only-in-PEND semantics; irq_take_i outside PEND SHALL have no effect.
REQ-029 Latency: qualified request to cyc_o=1 SHALL be exactly 1 clock; ack_i to irq_valid_o=1 SHALL be exactly 1 clock.

Reset
REQ-030 While rst_ni=0, SHALL asynchronously force: FSM=IDLE; cyc_o, stb_o, we_o, irq_valid_o, irq_nmi_o and irq_spurious_o =0; cti_o=3'b000; sel_o=4'h0; adr_o=0; irq_level_o=0; irq_cause_o=0; NMI-pending=0; captured-input registers=0.
REQ-031 Reset asserted mid-INTA SHALL drop cyc_o immediately and leave no pending request after release.

Structure
REQ-032 SHALL place in the Thor2023 shared package: the FSM state enum, the CTI constant 3'b110, the INTA address prefix 28'hFFFFFFF and the broadcast core code 6'h3F.
REQ-033 SHALL be a single module with no sub-modules; the watchdog counter SHALL be log2(TIMEOUT)+1 bits wide.

Verification
REQ-034 Normal acknowledge: irq_i=5, cause_i=8'h33, core_i=0, ipl_i=2, ie_i=1 held 2 clocks -> adr_o=32'hFFFFFFFA with cti_o=3'b110; ack_i with dat_i=32'h33333333 -> irq_valid_o, irq_cause_o=8'h33, irq_level_o=5.
REQ-035 Masking: irq_i=3 with ipl_i=3, or core_i=2 with CORE_ID=0 -> cyc_o stays 0; core_i=6'h3F -> cycle issued.
REQ-036 NMI priority: nmi_i 0->1 in the same clock as a qualified irq_i=7 -> PEND with irq_nmi_o=1, cause 8'h02, no bus cycle; after irq_take_i -> INTA for level 7.
REQ-037 Vector pull and timeout: vp_i=1 in INTA -> cause equals the latched cause_i; no ack_i or vp_i for 16 clocks -> irq_cause_o=8'd24 and irq_spurious_o=1.
REQ-038 Reset mid-cycle: rst_ni=0 during INTA -> cyc_o=0 asynchronously; after release, no irq_valid_o until a new 2-clock qualification.

Source files
------------

// File: rtl/thor2023_inta_master_pkg.sv
// thor2023_inta_master_pkg: shared Thor2023 interrupt-acknowledge types and bus constants.
package thor2023_inta_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INTA = 2'd1,
        PEND = 2'd2
    } inta_state_t;

    localparam logic [2:0]  INTA_CTI        = 3'b110;
    localparam logic [27:0] INTA_ADR_PREFIX = 28'hFFFFFFF;
    localparam logic [5:0]  BCAST_CORE      = 6'h3F;

endpackage

// File: rtl/thor2023_inta_master.sv
// thor2023_inta_master: qualifies controller requests, runs the interrupt-acknowledge
// bus cycle and presents level/cause to the core until it takes the interrupt.
module thor2023_inta_master
    import thor2023_inta_master_pkg::*;
#(
    parameter logic [5:0]  CORE_ID        = 6'd0,
    parameter logic [7:0]  NMI_CAUSE      = 8'h02,
    parameter logic [7:0]  SPURIOUS_CAUSE = 8'd24,
    parameter int unsigned TIMEOUT        = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [3:0]  irq_i,
    input  logic [7:0]  cause_i,
    input  logic [5:0]  core_i,
    input  logic        nmi_i,
    input  logic [3:0]  ipl_i,
    input  logic        ie_i,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [2:0]  cti_o,
    output logic [3:0]  sel_o,
    output logic [31:0] adr_o,
    input  logic        ack_i,
    input  logic [31:0] dat_i,
    input  logic        vp_i,
    output logic        irq_valid_o,
    output logic        irq_nmi_o,
    output logic        irq_spurious_o,
    output logic [3:0]  irq_level_o,
    output logic [7:0]  irq_cause_o,
    input  logic        irq_take_i
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    inta_state_t   state;
    logic [3:0]    irq_q;
    logic [7:0]    cause_q;
    logic [5:0]    core_q;
    logic          cond_q;
    logic          nmi_q;
    logic          nmi_pend;
    logic [CW-1:0] wd;
    logic          cond;
    logic          qual;
    logic          nmi_edge;
    logic          wd_done;
    logic          unused_dat;

    assign we_o       = 1'b0;
    assign unused_dat = ^dat_i[31:8];

    always_comb begin
        cond     = irq_i != 4'd0 && irq_i > ipl_i && ie_i && (core_i == CORE_ID || core_i == BCAST_CORE);
        qual     = cond && cond_q && irq_i == irq_q && cause_i == cause_q && core_i == core_q;
        nmi_edge = nmi_i & ~nmi_q;
        wd_done  = wd == CW'(TIMEOUT - 1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            irq_q          <= '0;
            cause_q        <= '0;
            core_q         <= '0;
            cond_q         <= 1'b0;
            nmi_q          <= 1'b0;
            nmi_pend       <= 1'b0;
            wd             <= '0;
            cyc_o          <= 1'b0;
            stb_o          <= 1'b0;
            cti_o          <= 3'b000;
            sel_o          <= 4'h0;
            adr_o          <= '0;
            irq_valid_o    <= 1'b0;
            irq_nmi_o      <= 1'b0;
            irq_spurious_o <= 1'b0;
            irq_level_o    <= '0;
            irq_cause_o    <= '0;
        end else begin
            irq_q    <= irq_i;
            cause_q  <= cause_i;
            core_q   <= core_i;
            nmi_q    <= nmi_i;
            // qualification history only accrues while idle, forcing a fresh 2-clock window after PEND
            cond_q   <= cond && state == IDLE;
            nmi_pend <= nmi_pend | nmi_edge;
            case (state)
                IDLE: begin
                    if (nmi_pend || nmi_edge) begin
                        state       <= PEND;
                        nmi_pend    <= 1'b0;
                        irq_valid_o <= 1'b1;
                        irq_nmi_o   <= 1'b1;
                        irq_level_o <= 4'hF;
                        irq_cause_o <= NMI_CAUSE;
                    end else if (qual) begin
                        state       <= INTA;
                        wd          <= '0;
                        cyc_o       <= 1'b1;
                        stb_o       <= 1'b1;
                        cti_o       <= INTA_CTI;
                        sel_o       <= 4'hF;
                        adr_o       <= {INTA_ADR_PREFIX, irq_i[2:0], 1'b0};
                        irq_level_o <= irq_i;
                        irq_cause_o <= cause_i;
                    end
                end
                INTA: begin
                    wd <= wd + 1'b1;
                    if (ack_i || vp_i || wd_done) begin
                        state       <= PEND;
                        cyc_o       <= 1'b0;
                        stb_o       <= 1'b0;
                        cti_o       <= 3'b000;
                        sel_o       <= 4'h0;
                        adr_o       <= '0;
                        irq_valid_o <= 1'b1;
                        if (ack_i) begin
                            irq_cause_o    <= dat_i[7:0];
                            irq_spurious_o <= dat_i[7:0] == SPURIOUS_CAUSE;
                        end else if (!vp_i) begin
                            irq_cause_o    <= SPURIOUS_CAUSE;
                            irq_spurious_o <= 1'b1;
                        end
                    end
                end
                PEND: begin
                    if (irq_take_i) begin
                        state          <= IDLE;
                        irq_valid_o    <= 1'b0;
                        irq_nmi_o      <= 1'b0;
                        irq_spurious_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
